// File: rtl/sram_byte_responder.sv
// Byte-read responder over a word SRAM: requests queue in a FIFO, one FSM serves them in order.
// Optional single-word read buffer is enabled by defining SRAM_RESP_WORD_BUFFER_EN.
module sram_byte_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter logic [31:0] SIZE_BYTES = 32'h0000_1000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  output logic [7:0]  rdata_o,
  output logic        rvalid_o,
  output logic        err_o,
  output logic        overflow_o,
  output logic        busy_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  function automatic logic [7:0] lane(input logic [31:0] w, input logic [1:0] sel);
    return w[{sel, 3'b000} +: 8];
  endfunction

  state_e        state_q, state_d;
  logic [31:0]   fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          overflow_q, overflow_d;
  logic [31:0]   addr_q, addr_d;
  logic [7:0]    rdat_q, rdat_d;
  logic          rerr_q, rerr_d;

  logic          fifo_empty, fifo_full, push, pop, drop;
  logic [31:0]   head_addr, head_off;
  logic          head_in_win, buf_hit;
  logic [7:0]    buf_byte;

  assign fifo_empty  = (cnt_q == '0);
  assign fifo_full   = (cnt_q == DEPTH_C);
  assign pop         = (state_q == IDLE) && !fifo_empty;
  assign push        = req_i && (!fifo_full || pop);
  assign drop        = req_i && fifo_full && !pop;
  assign head_addr   = fifo_q[rd_ptr_q];
  // Unsigned wrap makes addresses below BASE_ADDR land far outside the window.
  assign head_off    = head_addr - BASE_ADDR;
  assign head_in_win = (head_off < SIZE_BYTES);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    overflow_d = overflow_q | drop;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= addr_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef SRAM_RESP_WORD_BUFFER_EN
  logic        buf_vld_q;
  logic [29:0] buf_tag_q;
  logic [31:0] buf_dat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_vld_q <= 1'b0;
      buf_tag_q <= '0;
      buf_dat_q <= '0;
    end else if (state_q == WAIT && mem_rvalid_i) begin
      buf_vld_q <= 1'b1;
      buf_tag_q <= addr_q[31:2];
      buf_dat_q <= mem_rdata_i;
    end
  end

  assign buf_hit  = buf_vld_q && (buf_tag_q == head_addr[31:2]);
  assign buf_byte = lane(buf_dat_q, head_addr[1:0]);
`else
  assign buf_hit  = 1'b0;
  assign buf_byte = 8'h00;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          if (!head_in_win || buf_hit) state_d = RESP;
          else                         state_d = ISSUE;
        end
      end
      ISSUE:   if (mem_gnt_i)    state_d = WAIT;
      WAIT:    if (mem_rvalid_i) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Response data/err are settled before RESP so the strobe cycle only gates them.
  always_comb begin
    addr_d = addr_q;
    rdat_d = rdat_q;
    rerr_d = rerr_q;
    if (pop) begin
      addr_d = head_addr;
      rerr_d = !head_in_win;
      rdat_d = (head_in_win && buf_hit) ? buf_byte : 8'h00;
    end else if (state_q == WAIT && mem_rvalid_i) begin
      rdat_d = lane(mem_rdata_i, addr_q[1:0]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      rdat_q <= '0;
      rerr_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      rdat_q <= rdat_d;
      rerr_q <= rerr_d;
    end
  end

  always_comb begin
    rvalid_o   = 1'b0;
    rdata_o    = 8'h00;
    err_o      = 1'b0;
    mem_req_o  = 1'b0;
    mem_addr_o = 32'h0;
    overflow_o = overflow_q;
    busy_o     = !fifo_empty || (state_q != IDLE);
    case (state_q)
      ISSUE: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {addr_q[31:2], 2'b00};
      end
      RESP: begin
        rvalid_o = 1'b1;
        rdata_o  = rdat_q;
        err_o    = rerr_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_byte_responder.sv
// Self-checking bench for sram_byte_responder: vector table, overflow burst and reset-in-WAIT sequence.
module tb_sram_byte_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_i = 1'b0;
  logic [31:0] addr_i = 32'h0;
  logic [7:0]  rdata_o;
  logic        rvalid_o, err_o, overflow_o, busy_o, mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'h0;

  sram_byte_responder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req_i),
    .addr_i       (addr_i),
    .rdata_o      (rdata_o),
    .rvalid_o     (rvalid_o),
    .err_o        (err_o),
    .overflow_o   (overflow_o),
    .busy_o       (busy_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef SRAM_RESP_WORD_BUFFER_EN
  localparam bit BUF_MISS = 1'b0;
`else
  localparam bit BUF_MISS = 1'b1;
`endif

  typedef struct {
    logic [31:0] addr;
    int          gnt_dly;
    bit          miss;
    logic [7:0]  dat;
    bit          err;
    string       name;
  } vec_t;

  typedef struct packed {
    logic [7:0] dat;
    logic       err;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;

  bit          bk_auto = 1'b1;
  int          gnt_wait = 0;
  bit          pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  logic [31:0] last_mem_addr = 32'h0;
  int          bk_rv_cyc = 0;
  int          mem_req_cnt = 0;
  int          resp_cnt = 0;
  int          last_resp_cyc = 0;
  bit          prev_hold = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  // Reference memory: one fixed word for the named scenarios, a pattern elsewhere.
  function automatic logic [31:0] ref_word(input logic [31:0] wa);
    if (wa == 32'h1000_0004) return 32'hDDCC_BBAA;
    return {wa[7:0] + 8'd3, wa[7:0] + 8'd2, wa[7:0] + 8'd1, wa[7:0]} ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [31:0] a);
    logic [31:0] w;
    w = ref_word({a[31:2], 2'b00});
    return w[{a[1:0], 3'b000} +: 8];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic backend();
    forever begin
      @(posedge clk);
      #1;
      if (bk_auto) begin
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        if (pend) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = ref_word(pend_addr);
          bk_rv_cyc    = cyc;
          pend         = 1'b0;
        end
        if (mem_req_o) begin
          if (gnt_wait > 0) begin
            gnt_wait--;
          end else begin
            mem_gnt_i     = 1'b1;
            pend          = 1'b1;
            pend_addr     = mem_addr_o;
            last_mem_addr = mem_addr_o;
          end
        end
      end
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold = 1'b0;
      end else begin
        if (mem_req_o) begin
          mem_req_cnt++;
          chk("mem_addr_align", 32'(mem_addr_o[1:0]), 32'h0);
          if (prev_hold) chk("mem_addr_stable", mem_addr_o, prev_addr);
        end
        prev_hold = mem_req_o && !mem_gnt_i;
        prev_addr = mem_addr_o;
        if (rvalid_o) begin
          resp_cnt++;
          last_resp_cyc = cyc;
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: actual rdata %0h err %0b, required no response", rdata_o, err_o);
          end else begin
            e = sb_q.pop_front();
            chk("resp_rdata", 32'(rdata_o), 32'(e.dat));
            chk("resp_err", 32'(err_o), 32'(e.err));
          end
        end else begin
          chk("idle_rdata", 32'(rdata_o), 32'h0);
          chk("idle_err", 32'(err_o), 32'h0);
        end
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    int   t0, mc0, rc0, n;
    exp_t e;
    @(posedge clk);
    #1;
    gnt_wait = v.gnt_dly;
    mc0      = mem_req_cnt;
    rc0      = resp_cnt;
    e.dat    = v.dat;
    e.err    = v.err;
    sb_q.push_back(e);
    req_i    = 1'b1;
    addr_i   = v.addr;
    t0       = cyc;
    @(posedge clk);
    #1;
    req_i = 1'b0;
    n = 0;
    while (resp_cnt == rc0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (resp_cnt == rc0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: actual no response, required one response", v.name);
      sb_q.delete();
    end else if (v.miss) begin
      chk({v.name, "_mem_access"}, 32'(mem_req_cnt > mc0), 32'h1);
      chk({v.name, "_mem_addr"}, last_mem_addr, {v.addr[31:2], 2'b00});
      chk({v.name, "_miss_latency"}, 32'(last_resp_cyc), 32'(bk_rv_cyc + 1));
    end else begin
      chk({v.name, "_no_mem_access"}, 32'(mem_req_cnt), 32'(mc0));
      chk({v.name, "_latency"}, 32'(last_resp_cyc), 32'(t0 + 2));
    end
  endtask

  initial begin
    vec_t vt[10];
    exp_t e;
    int   rc0, n;

    vt[0] = '{32'h1000_0005, 2, 1'b1,     8'hBB, 1'b0, "miss_0005"};
    vt[1] = '{32'h1000_0007, 0, BUF_MISS, 8'hDD, 1'b0, "word_0007"};
    vt[2] = '{32'h1000_1000, 0, 1'b0,     8'h00, 1'b1, "oow_above"};
    vt[3] = '{32'h0FFF_FFFF, 0, 1'b0,     8'h00, 1'b1, "oow_below"};
    vt[4] = '{32'h1000_0000, 0, 1'b1,     exp_byte(32'h1000_0000), 1'b0, "first_byte"};
    vt[5] = '{32'h1000_0FFF, 1, 1'b1,     exp_byte(32'h1000_0FFF), 1'b0, "last_byte"};
    vt[6] = '{32'h0000_0000, 0, 1'b0,     8'h00, 1'b1, "oow_zero"};
    vt[7] = '{32'hFFFF_FFFF, 0, 1'b0,     8'h00, 1'b1, "oow_top"};
    vt[8] = '{32'h1000_0006, 3, 1'b1,     8'hCC, 1'b0, "miss_0006"};
    vt[9] = '{32'h1000_0004, 0, BUF_MISS, 8'hAA, 1'b0, "word_0004"};

    fork
      backend();
      monitor();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rvalid",   32'(rvalid_o),   32'h0);
    chk("rst_rdata",    32'(rdata_o),    32'h0);
    chk("rst_err",      32'(err_o),      32'h0);
    chk("rst_overflow", 32'(overflow_o), 32'h0);
    chk("rst_busy",     32'(busy_o),     32'h0);
    chk("rst_mem_req",  32'(mem_req_o),  32'h0);
    chk("rst_mem_addr", mem_addr_o,      32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vt[i]);

    // One request enters the FSM and four fill the FIFO while the grant is withheld.
    @(posedge clk);
    #1;
    gnt_wait = 20;
    rc0 = resp_cnt;
    for (int i = 0; i < 9; i++) begin
      req_i  = 1'b1;
      addr_i = 32'h1000_0000 + 32'(i);
      if (i < 5) begin
        e.dat = exp_byte(addr_i);
        e.err = 1'b0;
        sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    req_i = 1'b0;
    @(negedge clk);
    chk("burst_overflow_set", 32'(overflow_o), 32'h1);
    n = 0;
    while (resp_cnt < rc0 + 5 && n < 400) begin
      @(posedge clk);
      n++;
    end
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("burst_resp_count", 32'(resp_cnt - rc0), 32'd5);
    chk("burst_sb_empty",   32'(sb_q.size()),    32'h0);
    chk("burst_busy_clear", 32'(busy_o),         32'h0);
    chk("burst_overflow_sticky", 32'(overflow_o), 32'h1);

    // Reset while waiting on backend data; the late data must not produce a response.
    bk_auto = 1'b0;
    @(posedge clk);
    #1;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    req_i  = 1'b1;
    addr_i = 32'h1000_0010;
    @(posedge clk);
    #1;
    req_i = 1'b0;
    n = 0;
    while (!mem_req_o && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rstw_issue", 32'(mem_req_o), 32'h1);
    mem_gnt_i = 1'b1;
    @(posedge clk);
    #1;
    mem_gnt_i = 1'b0;
    chk("rstw_busy_in_wait", 32'(busy_o), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstw_rvalid",   32'(rvalid_o),   32'h0);
    chk("rstw_overflow", 32'(overflow_o), 32'h0);
    chk("rstw_busy",     32'(busy_o),     32'h0);
    chk("rstw_mem_req",  32'(mem_req_o),  32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rc0 = resp_cnt;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h1234_5678;
    @(posedge clk);
    #1;
    mem_rvalid_i = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rstw_no_resp",      32'(resp_cnt - rc0), 32'h0);
    chk("rstw_post_rdata",   32'(rdata_o),        32'h0);
    chk("rstw_post_err",     32'(err_o),          32'h0);
    chk("rstw_post_overflow", 32'(overflow_o),    32'h0);
    chk("rstw_post_busy",    32'(busy_o),         32'h0);
    chk("rstw_post_mem_addr", mem_addr_o,         32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
